// File: rtl/if_stage_pkg.sv
// ============================================================================
// Module   : if_stage_pkg
// Brief    : Shared constants and the fetch-FSM state type for the IF stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package if_stage_pkg;

  localparam int          InstAddrWidth = 32;
  localparam int          InstWidth     = 32;
  localparam logic        ChipEnable    = 1'b1;
  localparam logic        ChipDisable   = 1'b0;
  localparam logic [31:0] ZeroWord      = 32'h0000_0000;
  localparam logic [31:0] PcStep        = 32'd4;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } if_state_t;

endpackage

`default_nettype wire

// File: rtl/if_stage_pc_reg.sv
// ============================================================================
// Module   : pc_reg
// Brief    : Program counter with flush > branch > increment priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        advance,
  output logic [31:0] pc
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Redirect targets are forced word-aligned; the ROM only serves whole words.
  always_comb begin
    pc_d = pc_q;
    if (flush) begin
      pc_d = flush_pc & ~32'h3;
    end else if (branch_flag) begin
      pc_d = branch_target & ~32'h3;
    end else if (advance) begin
      pc_d = pc_q + PcStep;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch: ROM control, IF/ID register, fetch counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  input  logic        id_ready,
  output logic [31:0] fetch_cnt
);

  if_state_t   state_q, state_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        advance;
  logic        redirect;
  logic [31:0] pc;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .advance       (advance),
    .pc            (pc)
  );

  assign redirect = flush | branch_flag;

  always_comb begin
    state_d     = state_q;
    id_valid_d  = id_valid_q;
    id_pc_d     = id_pc_q;
    id_inst_d   = id_inst_q;
    fetch_cnt_d = fetch_cnt_q;
    advance     = 1'b0;
    // A redirect kills the held instruction even when decode is stalled.
    if (redirect) begin
      id_valid_d = 1'b0;
      state_d    = S_FETCH;
    end else begin
      case (state_q)
        S_RESET: state_d = S_FETCH;
        S_FETCH: begin
          if (!id_valid_q || id_ready) begin
            id_pc_d     = pc;
            id_inst_d   = rom_inst;
            id_valid_d  = 1'b1;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
            advance     = 1'b1;
          end else begin
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (id_ready) begin
            id_valid_d = 1'b0;
            state_d    = S_FETCH;
          end
        end
        default: state_d = S_RESET;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RESET;
      id_valid_q  <= 1'b0;
      id_pc_q     <= ZeroWord;
      id_inst_q   <= ZeroWord;
      fetch_cnt_q <= ZeroWord;
    end else begin
      state_q     <= state_d;
      id_valid_q  <= id_valid_d;
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign rom_ce    = (state_q == S_FETCH) ? ChipEnable : ChipDisable;
  assign rom_addr  = pc;
  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign id_inst   = id_inst_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module   : tb_if_stage
// Brief    : Directed vector table plus random stimulus against a fetch model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;
  logic [31:0] fetch_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // ROM contents: word k holds (k+1)*0x11, so words 0..3 are 0x11..0x44.
  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h11;
  endfunction

  assign rom_inst = rom_fn(rom_addr);

  if_stage #(.RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .rom_ce        (rom_ce),
    .rom_addr      (rom_addr),
    .rom_inst      (rom_inst),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_ready      (id_ready),
    .fetch_cnt     (fetch_cnt)
  );

  // Behavioural reference: what the fetch unit should present after each edge.
  logic [31:0] m_pc, m_id_pc, m_id_inst, m_cnt;
  logic        m_valid, m_boot, m_stall;

  task automatic model_step();
    logic [31:0] tgt;
    if (rst) begin
      m_pc = 32'h0; m_boot = 1'b1; m_stall = 1'b0; m_valid = 1'b0;
      m_id_pc = 32'h0; m_id_inst = 32'h0; m_cnt = 32'h0;
    end else if (flush || branch_flag) begin
      tgt     = flush ? flush_pc : branch_target;
      m_pc    = {tgt[31:2], 2'b00};
      m_valid = 1'b0; m_boot = 1'b0; m_stall = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_stall) begin
      if (id_ready) begin
        m_valid = 1'b0; m_stall = 1'b0;
      end
    end else if (!m_valid || id_ready) begin
      m_id_pc = m_pc; m_id_inst = rom_fn(m_pc); m_valid = 1'b1;
      m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
    end else begin
      m_stall = 1'b1;
    end
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic        rst, flush, br, rdy;
    logic [31:0] fpc, btgt;
    logic        e_valid, e_ce;
    logic [31:0] e_pc, e_inst, e_addr, e_cnt;
  } vec_t;

  vec_t tbl[23];

  initial begin
    rst = 1'b1; flush = 1'b0; flush_pc = 32'h0; branch_flag = 1'b0;
    branch_target = 32'h0; id_ready = 1'b1;

    //            rst fl br rdy fpc          btgt          vld ce  id_pc         id_inst       addr          cnt
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b1,32'h0,32'h0,         1'b0,1'b0,32'h0,32'h0,          32'h0,        32'd0};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b1,32'h0,32'h0,         1'b0,1'b1,32'h0,32'h0,          32'h0,        32'd0};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b1,32'h0,32'h0,         1'b1,1'b1,32'h0,32'h11,         32'h4,        32'd1};
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b1,32'h0,32'h0,         1'b1,1'b1,32'h4,32'h22,         32'h8,        32'd2};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b1,32'h0,32'h0,         1'b1,1'b1,32'h8,32'h33,         32'hC,        32'd3};
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b1,32'h0,32'h0,         1'b1,1'b1,32'hC,32'h44,         32'h10,       32'd4};
    tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,         1'b1,1'b0,32'hC,32'h44,         32'h10,       32'd4};
    tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,         1'b1,1'b0,32'hC,32'h44,         32'h10,       32'd4};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,         1'b1,1'b0,32'hC,32'h44,         32'h10,       32'd4};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b1,32'h0,32'h0,         1'b0,1'b1,32'hC,32'h44,         32'h10,       32'd4};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b1,32'h0,32'h0,         1'b1,1'b1,32'h10,32'h55,        32'h14,       32'd5};
    tbl[11] = '{1'b0,1'b0,1'b1,1'b1,32'h0,32'h40,        1'b0,1'b1,32'h10,32'h55,        32'h40,       32'd5};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b1,32'h0,32'h0,         1'b1,1'b1,32'h40,32'h121,       32'h44,       32'd6};
    tbl[13] = '{1'b0,1'b1,1'b1,1'b1,32'h83,32'h40,       1'b0,1'b1,32'h40,32'h121,       32'h80,       32'd6};
    tbl[14] = '{1'b0,1'b0,1'b0,1'b1,32'h0,32'h0,         1'b1,1'b1,32'h80,32'h231,       32'h84,       32'd7};
    tbl[15] = '{1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,         1'b1,1'b0,32'h80,32'h231,       32'h84,       32'd7};
    tbl[16] = '{1'b0,1'b1,1'b1,1'b0,32'h80,32'h40,       1'b0,1'b1,32'h80,32'h231,       32'h80,       32'd7};
    tbl[17] = '{1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,         1'b1,1'b1,32'h80,32'h231,       32'h84,       32'd8};
    tbl[18] = '{1'b0,1'b0,1'b1,1'b1,32'h0,32'hFFFF_FFFC, 1'b0,1'b1,32'h80,32'h231,       32'hFFFF_FFFC,32'd8};
    tbl[19] = '{1'b0,1'b0,1'b0,1'b1,32'h0,32'h0,         1'b1,1'b1,32'hFFFF_FFFC,32'h4000_0000,32'h0, 32'd9};
    tbl[20] = '{1'b1,1'b0,1'b1,1'b1,32'h0,32'h40,        1'b0,1'b0,32'h0,32'h0,          32'h0,        32'd0};
    tbl[21] = '{1'b0,1'b0,1'b1,1'b1,32'h0,32'h40,        1'b0,1'b1,32'h0,32'h0,          32'h40,       32'd0};
    tbl[22] = '{1'b0,1'b0,1'b0,1'b1,32'h0,32'h0,         1'b1,1'b1,32'h40,32'h121,       32'h44,       32'd1};

    for (int i = 0; i < 23; i++) begin
      rst = tbl[i].rst; flush = tbl[i].flush; branch_flag = tbl[i].br;
      id_ready = tbl[i].rdy; flush_pc = tbl[i].fpc; branch_target = tbl[i].btgt;
      tick();
      chk("id_valid",  i, {31'b0, id_valid}, {31'b0, tbl[i].e_valid});
      chk("rom_ce",    i, {31'b0, rom_ce},   {31'b0, tbl[i].e_ce});
      chk("id_pc",     i, id_pc,     tbl[i].e_pc);
      chk("id_inst",   i, id_inst,   tbl[i].e_inst);
      chk("rom_addr",  i, rom_addr,  tbl[i].e_addr);
      chk("fetch_cnt", i, fetch_cnt, tbl[i].e_cnt);
    end

    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 63) == 0);
      flush         = ($urandom_range(0, 15) == 0);
      branch_flag   = ($urandom_range(0, 7) == 0);
      flush_pc      = $urandom();
      branch_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + ($urandom() & 32'h7)
                                                  : ($urandom() & 32'h0000_0FFF);
      id_ready      = ($urandom_range(0, 9) < 7);
      tick();
      chk("r_id_valid",  1000 + i, {31'b0, id_valid}, {31'b0, m_valid});
      chk("r_rom_ce",    1000 + i, {31'b0, rom_ce},   {31'b0, !m_boot && !m_stall});
      chk("r_rom_addr",  1000 + i, rom_addr,  m_pc);
      chk("r_id_pc",     1000 + i, id_pc,     m_id_pc);
      chk("r_id_inst",   1000 + i, id_inst,   m_id_inst);
      chk("r_fetch_cnt", 1000 + i, fetch_cnt, m_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
